// File: rtl/mclaurin_pkg.sv
`default_nettype none
// ============================================================================
// mclaurin_pkg: shared types and widths for the mclaurin_scheduler slice.
// Rev 1.0
// ============================================================================
package mclaurin_pkg;

  localparam int MCL_X_W  = 8;
  localparam int MCL_N_W  = 3;
  localparam int MCL_Y_W  = 32;
  localparam int MCL_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic                valid;
    logic [MCL_ID_W-1:0] id;
    logic                err;
  } tag_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mclaurin_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter: combinational round-robin arbiter, priority starts at last+1.
// Rev 1.0
// ============================================================================
module rr_arbiter
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last) + off) % NUM_REQ;
      if (!grant_any && req[ID_W'(cand)]) begin
        grant[ID_W'(cand)] = 1'b1;
        grant_idx          = ID_W'(cand);
        grant_any          = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mclaurin_scheduler.sv
`default_nettype none
// ============================================================================
// mclaurin_scheduler: shares one mclaurin_pipeline among NUM_REQ requesters.
// Rev 1.0
// ============================================================================
module mclaurin_scheduler
  import mclaurin_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int PIPE_LAT = 4,
  parameter  int MAX_N    = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [MCL_X_W*NUM_REQ-1:0] req_x,
  input  logic [MCL_N_W*NUM_REQ-1:0] req_n,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [MCL_X_W-1:0]         pipe_x,
  output logic [MCL_N_W-1:0]         pipe_n,
  input  logic [MCL_Y_W-1:0]         pipe_y,
  input  logic                       pipe_ovf,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [MCL_Y_W-1:0]         rsp_y,
  output logic                       rsp_ovf,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [15:0]                issue_cnt,
  output logic [15:0]                ovf_cnt
);

  sched_state_t         state;
  logic [NUM_REQ-1:0]   pend;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   rsp_clr;
  logic [ID_W-1:0]      last;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;
  logic [MCL_X_W-1:0]   sel_x;
  logic [MCL_N_W-1:0]   sel_n;
  logic                 sel_err;
  logic                 tail_ok;
  tag_t                 tag_sr [PIPE_LAT+1];

  // Dropping enable stops grants in the same cycle, before the FSM leaves RUN
  assign eligible  = (state == RUN && enable) ? (req_valid & ~pend) : '0;
  assign req_ready = grant;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ)
  ) u_arb (
    .req       (eligible),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_x   = req_x[int'(grant_idx)*MCL_X_W +: MCL_X_W];
    sel_n   = req_n[int'(grant_idx)*MCL_N_W +: MCL_N_W];
    sel_err = int'(sel_n) > MAX_N;
    tail_ok = tag_sr[PIPE_LAT].valid && !tag_sr[PIPE_LAT].err;
  end

  always_comb begin
    rsp_clr = '0;
    if (rsp_valid) rsp_clr[rsp_id] = 1'b1;
  end

  always_comb begin
    busy = rsp_valid;
    for (int k = 0; k <= PIPE_LAT; k++) busy = busy | tag_sr[k].valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend      <= '0;
      last      <= ID_W'(NUM_REQ - 1);
      pipe_x    <= '0;
      pipe_n    <= '0;
      for (int k = 0; k <= PIPE_LAT; k++) tag_sr[k] <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
      issue_cnt <= '0;
      ovf_cnt   <= '0;
    end else begin
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= busy ? DRAIN : IDLE;
        DRAIN:   if (!busy) state <= IDLE;
        default: state <= IDLE;
      endcase

      pend <= (pend & ~rsp_clr) | grant;
      if (grant_any) last <= grant_idx;

      // Illegal precision is never sent to the pipeline; its slot becomes zeros
      pipe_x <= (grant_any && !sel_err) ? sel_x : '0;
      pipe_n <= (grant_any && !sel_err) ? sel_n : '0;

      tag_sr[0].valid <= grant_any;
      tag_sr[0].id    <= MCL_ID_W'(grant_idx);
      tag_sr[0].err   <= grant_any & sel_err;
      for (int k = 1; k <= PIPE_LAT; k++) tag_sr[k] <= tag_sr[k-1];

      rsp_valid <= tag_sr[PIPE_LAT].valid;
      rsp_id    <= ID_W'(tag_sr[PIPE_LAT].id);
      rsp_y     <= tail_ok ? pipe_y : '0;
      rsp_ovf   <= tail_ok & pipe_ovf;
      rsp_err   <= tag_sr[PIPE_LAT].valid & tag_sr[PIPE_LAT].err;

      if (grant_any) issue_cnt <= sat_inc(issue_cnt);
      if (rsp_valid && rsp_ovf) ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

endmodule
`default_nettype wire
